// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
//   pc_src_e      : pc_source encodings used when pc_write selects the target
//   BR_BEQ/BR_BNE : br_mode encodings (branch sense)
//   DEF_*_VEC     : default reset and trap vectors
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      SRC_RESULT = 2'b00,
      SRC_ALU    = 2'b01,
      SRC_JUMP   = 2'b10,
      SRC_REG    = 2'b11
   } pc_src_e;

   localparam logic BR_BEQ = 1'b0;
   localparam logic BR_BNE = 1'b1;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst   : clock, synchronous active-low reset
//   push, pop  : single-cycle requests (never both at once)
//   push_data  : address pushed on push
//   top        : newest entry, 0 when empty
//   count      : occupancy 0..DEPTH; empty/full flags derived from it
// A push when full writes over the oldest slot, which is the slot the write
// pointer already points at, so wrap-around needs no special case.
module pc_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [XLEN-1:0]            push_data,
   output logic [XLEN-1:0]            top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr;   // next free slot; ptr-1 is the top

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign top   = empty ? '0 : mem[ptr - PW'(1)];

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PW'(1);
         if (!full) count <= count + CW'(1);
      end else if (pop && !empty) begin
         ptr   <= ptr - PW'(1);
         count <= count - CW'(1);
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (rst && push) mem[ptr] <= push_data;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/jump/JR selection, exception
// entry/return, misalignment trap and a return-address stack.
//   clk, rst                  : clock, synchronous active-low reset
//   pc_write, pc_write_cond   : unconditional / conditional update enables
//   br_mode, zero             : branch sense and ALU zero flag
//   pc_source                 : target select for pc_write
//   result, alu_out, reg_val  : candidate targets; ir_low26 : jump index
//   link                      : jump-and-link (push on RAS)
//   exc_req, eret             : trap entry / return
//   pc_value, epc             : current PC, saved exception PC
//   ras_top, ras_count, ras_empty, ras_full : RAS status
//   misalign_exc              : one-cycle pulse after a misaligned target trap
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
   parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC),
   parameter int              RAS_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pc_write,
   input  logic                           pc_write_cond,
   input  logic                           br_mode,
   input  logic                           zero,
   input  logic [1:0]                     pc_source,
   input  logic [XLEN-1:0]                result,
   input  logic [XLEN-1:0]                alu_out,
   input  logic [XLEN-1:0]                reg_val,
   input  logic [25:0]                    ir_low26,
   input  logic                           link,
   input  logic                           exc_req,
   input  logic                           eret,
   output logic [XLEN-1:0]                pc_value,
   output logic [XLEN-1:0]                epc,
   output logic [XLEN-1:0]                ras_top,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_empty,
   output logic                           ras_full,
   output logic                           misalign_exc
);

   localparam logic [XLEN-1:0] HI_MASK = {4'hF, {(XLEN-4){1'b0}}};

   logic            taken;
   logic [XLEN-1:0] jmp_tgt, sel_tgt, tgt;
   logic [XLEN-1:0] pc_nxt, epc_nxt;
   logic            mis_nxt, push, pop;

   assign taken   = pc_write_cond && ((br_mode == BR_BNE) ? !zero : zero);
   // Upper nibble comes from the current (pre-update) PC.
   assign jmp_tgt = (pc_value & HI_MASK) | XLEN'({ir_low26, 2'b00});

   always_comb begin
      sel_tgt = result;
      case (pc_src_e'(pc_source))
         SRC_RESULT: sel_tgt = result;
         SRC_ALU:    sel_tgt = alu_out;
         SRC_JUMP:   sel_tgt = jmp_tgt;
         SRC_REG:    sel_tgt = reg_val;
         default:    sel_tgt = result;
      endcase
   end

   // Branches always go to alu_out whatever pc_source says.
   assign tgt = taken ? alu_out : sel_tgt;

   always_comb begin
      pc_nxt  = pc_value;
      epc_nxt = epc;
      mis_nxt = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      if (exc_req) begin
         epc_nxt = pc_value;
         pc_nxt  = EXC_VEC;
      end else if (eret) begin
         pc_nxt = epc;
      end else if (taken || pc_write) begin
         if (tgt[1:0] != 2'b00) begin
            epc_nxt = pc_value;
            pc_nxt  = EXC_VEC;
            mis_nxt = 1'b1;
         end else begin
            pc_nxt = tgt;
            push   = !taken && (pc_src_e'(pc_source) == SRC_JUMP) && link;
            pop    = !taken && (pc_src_e'(pc_source) == SRC_REG);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_value     <= RESET_VEC;
         epc          <= '0;
         misalign_exc <= 1'b0;
      end else begin
         pc_value     <= pc_nxt;
         epc          <= epc_nxt;
         misalign_exc <= mis_nxt;
      end
   end

   pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_value),
      .top       (ras_top),
      .count     (ras_count),
      .empty     (ras_empty),
      .full      (ras_full)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RVEC  = 32'h0000_0400;
   localparam logic [31:0] EVEC  = 32'h0000_0180;

   logic        clk = 1'b0;
   logic        rst, pc_write, pc_write_cond, br_mode, zero, link, exc_req, eret;
   logic [1:0]  pc_source;
   logic [31:0] result, alu_out, reg_val;
   logic [25:0] ir_low26;
   logic [31:0] pc_value, epc, ras_top;
   logic [2:0]  ras_count;
   logic        ras_empty, ras_full, misalign_exc;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [31:0] m_pc = '0, m_epc = '0;
   logic        m_mis = 1'b0;
   logic [31:0] m_ras[$];

   always #5 clk = ~clk;

   pc_sequencer #(.XLEN(XLEN), .RESET_VEC(RVEC), .EXC_VEC(EVEC), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .br_mode(br_mode), .zero(zero), .pc_source(pc_source), .result(result),
      .alu_out(alu_out), .reg_val(reg_val), .ir_low26(ir_low26), .link(link),
      .exc_req(exc_req), .eret(eret), .pc_value(pc_value), .epc(epc),
      .ras_top(ras_top), .ras_count(ras_count), .ras_empty(ras_empty),
      .ras_full(ras_full), .misalign_exc(misalign_exc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pc_write = 0; pc_write_cond = 0; br_mode = 0; zero = 0; link = 0;
      exc_req = 0; eret = 0; pc_source = 2'b00;
   endtask

   // Apply the current inputs for one edge, advance the model, compare.
   task automatic step();
      logic        tk;
      logic [31:0] tgt;
      if (!rst) begin
         m_pc = RVEC; m_epc = 0; m_mis = 0; m_ras.delete();
      end else begin
         m_mis = 0;
         tk = pc_write_cond && (zero != br_mode);
         if (exc_req) begin
            m_epc = m_pc; m_pc = EVEC;
         end else if (eret) begin
            m_pc = m_epc;
         end else if (tk || pc_write) begin
            if (tk)                     tgt = alu_out;
            else if (pc_source == 2'd0) tgt = result;
            else if (pc_source == 2'd1) tgt = alu_out;
            else if (pc_source == 2'd2) tgt = {m_pc[31:28], ir_low26, 2'b00};
            else                        tgt = reg_val;
            if (tgt % 4 != 0) begin
               m_epc = m_pc; m_pc = EVEC; m_mis = 1;
            end else begin
               if (!tk && pc_source == 2'd2 && link) begin
                  m_ras.push_back(m_pc);
                  if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
               end
               if (!tk && pc_source == 2'd3 && m_ras.size() > 0) void'(m_ras.pop_back());
               m_pc = tgt;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("pc_value", pc_value, m_pc);
      chk("epc", epc, m_epc);
      chk("ras_top", ras_top, (m_ras.size() > 0) ? m_ras[$] : 32'h0);
      chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
      chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      chk("misalign_exc", 32'(misalign_exc), 32'(m_mis));
   endtask

   task automatic load_pc(input logic [31:0] v);
      idle(); pc_write = 1; pc_source = 2'b00; result = v;
      step();
      idle();
   endtask

   initial begin
      idle();
      rst = 0; result = 0; alu_out = 0; reg_val = 0; ir_low26 = 0;
      // reset, then hold with no enables
      step();
      rst = 1;
      for (int i = 0; i < 5; i++) begin
         result = $urandom; alu_out = $urandom; reg_val = $urandom; ir_low26 = 26'($urandom);
         step();
         chk("hold_pc", pc_value, RVEC);
         chk("hold_empty", 32'(ras_empty), 1);
      end

      // BNE taken / not taken
      idle(); pc_write_cond = 1; br_mode = 1; zero = 0; alu_out = 32'h40; pc_source = 2'b11;
      step();
      chk("bne_taken", pc_value, 32'h40);
      zero = 1; alu_out = 32'h80;
      step();
      chk("bne_not_taken", pc_value, 32'h40);
      // BEQ taken
      br_mode = 0; zero = 1; alu_out = 32'h88;
      step();
      chk("beq_taken", pc_value, 32'h88);

      // jump-and-link
      load_pc(32'h3000_0010);
      pc_write = 1; pc_source = 2'b10; link = 1; ir_low26 = 26'h10;
      step();
      chk("jal_pc", pc_value, 32'h3000_0040);
      chk("jal_top", ras_top, 32'h3000_0010);
      chk("jal_count", 32'(ras_count), 1);

      // four more link-jumps: overflow loses the oldest
      for (int i = 1; i < 5; i++) begin
         ir_low26 = 26'(16'h100 * i);
         step();
      end
      chk("ovf_full", 32'(ras_full), 1);
      chk("ovf_count", 32'(ras_count), 4);
      // five JR pops
      idle(); pc_write = 1; pc_source = 2'b11;
      for (int i = 0; i < 5; i++) begin
         reg_val = 32'h0000_2000 + 32'(i * 8);
         step();
      end
      chk("pop_count", 32'(ras_count), 0);
      chk("pop_top", ras_top, 0);

      // misaligned target trap, then eret
      load_pc(32'h20);
      pc_write = 1; pc_source = 2'b00; result = 32'h0000_0102;
      step();
      chk("mis_pc", pc_value, EVEC);
      chk("mis_epc", epc, 32'h20);
      chk("mis_pulse", 32'(misalign_exc), 1);
      idle();
      step();
      chk("mis_pulse_end", 32'(misalign_exc), 0);
      eret = 1;
      step();
      chk("eret_pc", pc_value, 32'h20);

      // exc_req beats eret and a taken branch
      idle(); exc_req = 1; eret = 1; pc_write_cond = 1; zero = 1; alu_out = 32'h500;
      step();
      chk("exc_prio_pc", pc_value, EVEC);
      chk("exc_prio_epc", epc, 32'h20);

      // reset during pending misalign pulse
      idle(); pc_write = 1; pc_source = 2'b01; alu_out = 32'h3;
      step();
      idle(); rst = 0; exc_req = 1;
      step();
      chk("rst_mid_mis", 32'(misalign_exc), 0);
      chk("rst_mid_pc", pc_value, RVEC);
      rst = 1; idle();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         rst           = ($urandom_range(0, 99) != 0);
         exc_req       = ($urandom_range(0, 19) == 0);
         eret          = ($urandom_range(0, 14) == 0);
         pc_write      = ($urandom_range(0, 2) != 0);
         pc_write_cond = ($urandom_range(0, 3) == 0);
         br_mode       = 1'($urandom);
         zero          = 1'($urandom);
         link          = 1'($urandom);
         pc_source     = 2'($urandom);
         result        = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         alu_out       = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         reg_val       = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         ir_low26      = 26'($urandom);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width in bits.
REQ-002 Parameter RESET_VEC, default 0, PC value loaded at reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0180, trap target address.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low (rst==0 at a rising clk edge resets).
REQ-007 pc_write  in  1  unconditional PC update enable.
REQ-008 pc_write_cond  in  1  conditional branch update enable.
REQ-009 br_mode  in  1  branch sense: 0 taken when zero==1 (BEQ), 1 taken when zero==0 (BNE).
REQ-010 zero  in  1  ALU zero flag.
REQ-011 pc_source  in  2  00 result, 01 alu_out, 10 jump {pc[XLEN-1:XLEN-4], ir_low26, 2'b00}, 11 reg_val (JR).
REQ-012 result, alu_out, reg_val  in  XLEN each  candidate targets.
REQ-013 ir_low26  in  26  jump index field.
REQ-014 link  in  1  with pc_source==10, marks jump-and-link (push to RAS).
REQ-015 exc_req  in  1  external exception request; eret  in  1  return from exception.
REQ-016 pc_value  out  XLEN  current PC; epc  out  XLEN  saved exception PC.
REQ-017 ras_top  out  XLEN  predicted return address; ras_count  out  $clog2(RAS_DEPTH+1)  occupancy.
REQ-018 ras_empty, ras_full  out  1 each; misalign_exc  out  1  one-cycle trap pulse.

Function
REQ-019 Per cycle, exactly one action by priority: exc_req > eret > taken branch > pc_write > hold.
REQ-020 exc_req: epc<=pc_value, pc_value<=EXC_VEC; RAS unchanged.
REQ-021 eret (no exc_req): pc_value<=epc; epc unchanged.
REQ-022 Taken branch = pc_write_cond && (zero ^ br_mode); target alu_out, regardless of pc_source.
REQ-023 pc_write (no higher action): target selected by pc_source per REQ-011.
REQ-024 Jump target uses pc_value upper 4 bits at the time of the update (pre-update value).
REQ-025 Any target (branch/pc_write) with bits[1:0]!=0: no load; epc<=pc_value, pc_value<=EXC_VEC, misalign_exc=1 next cycle for exactly one cycle; no RAS push/pop.
REQ-026 No enable active: pc_value and epc hold; never latch stale targets.
REQ-027 Push: pc_write, pc_source==10, link==1, aligned target: push pc_value onto RAS.
REQ-028 Push when full: overwrite oldest entry (circular), ras_count stays RAS_DEPTH.
REQ-029 Pop: pc_write, pc_source==11, aligned target: pop top if non-empty; pop when empty: no change.
REQ-030 ras_top = top entry when non-empty, 0 when empty; combinational from state.
REQ-031 ras_empty = (ras_count==0); ras_full = (ras_count==RAS_DEPTH).
REQ-032 Push and pop are mutually exclusive by encoding; no same-cycle conflict exists.

Reset
REQ-033 rst==0 at clk edge: pc_value=RESET_VEC, epc=0, ras_count=0, RAS pointer=0, misalign_exc=0; overrides all inputs including exc_req.
REQ-034 Reset mid-operation discards pending misalign pulse and RAS contents; no initial-block reliance.

Structure
REQ-035 Shared package holds pc_source encodings, br_mode encodings, default EXC_VEC/RESET_VEC constants.
REQ-036 One sub-module: pc_ras (parametrised circular stack, push/pop/top/count); next-PC selection stays in pc_sequencer.

Verification
REQ-037 rst=0 one edge, then rst=1 with no enables -> pc_value=RESET_VEC, stays constant 5 cycles, ras_empty=1.
REQ-038 pc_write_cond=1, br_mode=1, zero=0, alu_out=0x40 -> pc_value=0x40 next edge; zero=1 same setup -> pc_value unchanged.
REQ-039 pc_value=0x3000_0010, pc_write, pc_source=10, link=1, ir_low26=0x10 -> pc_value=0x3000_0040, ras_top=0x3000_0010, ras_count=1.
REQ-040 Five link-jumps with RAS_DEPTH=4 -> ras_full=1, count=4, oldest lost; five JR pops -> fifth leaves count=0, ras_top=0.
REQ-041 pc_write, pc_source=00, result=0x0000_0102 at pc_value=0x20 -> pc_value=EXC_VEC, epc=0x20, misalign_exc high exactly one cycle; then eret -> pc_value=0x20.
REQ-042 exc_req and eret and taken branch same cycle -> exc_req wins: pc_value=EXC_VEC, epc=old pc_value.
